// File: rtl/ehl_gpio_pkg.sv
// ehl_gpio_pkg: register indices, op codes and the shared register-update rule for the GPIO bank
package ehl_gpio_pkg;
    localparam logic [3:0] GDOR = 4'd0;
    localparam logic [3:0] GOER = 4'd1;
    localparam logic [3:0] GAFR = 4'd2;
    localparam logic [3:0] GPER = 4'd3;
    localparam logic [3:0] GIER = 4'd5;
    localparam logic [3:0] GISR = 4'd6;
    localparam logic [3:0] GIFR = 4'd7;
    localparam logic [3:0] GDIR = 4'd8;
    localparam logic [3:0] GCMR = 4'd9;
    localparam logic [1:0] OP_WR  = 2'd0;
    localparam logic [1:0] OP_SET = 2'd1;
    localparam logic [1:0] OP_CLR = 2'd2;
    localparam logic [1:0] OP_INV = 2'd3;

    function automatic logic [31:0] next_val(input logic [1:0] op, input logic [31:0] mask, input logic [31:0] old);
        return op == OP_WR  ? mask :
               op == OP_SET ? old | mask :
               op == OP_CLR ? old & ~mask : old ^ mask;
    endfunction

    function automatic logic is_rw_reg(input logic [3:0] r);
        return r <= GPER || r == GIER || r == GISR || r == GCMR;
    endfunction

    function automatic logic is_rd_reg(input logic [3:0] r);
        return is_rw_reg(r) || r == GIFR || r == GDIR;
    endfunction
endpackage

// File: rtl/ehl_gpio_bank_if.sv
// ehl_gpio_bank_if: rd/wr register bus between the bridge (master) and the GPIO bank (slave)
interface ehl_gpio_bank_if #(
    parameter int WIDTH  = 32,
    parameter int NPORTS = 2
);
    localparam int AW = 6 + $clog2(NPORTS);
    logic             wr;
    logic             rd;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             err;
    modport master (output wr, rd, addr, data_in, input data_out, rd_valid, err);
    modport slave  (input wr, rd, addr, data_in, output data_out, rd_valid, err);
endinterface

// File: rtl/ehl_gpio_port.sv
// ehl_gpio_port: one port's registers, input synchroniser, event detection and sticky flags
module ehl_gpio_port
    import ehl_gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [3:0]       i_reg,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_gdor,
    output logic [WIDTH-1:0] o_goer,
    output logic [WIDTH-1:0] o_gafr,
    output logic [WIDTH-1:0] o_gper,
    output logic             o_irq_req
);
    logic [WIDTH-1:0] r_gdor, r_goer, r_gafr, r_gper, r_gier, r_gisr, r_gifr, r_gcmr, r_prev;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_gdir, w_cur, w_next, w_edge, w_event;

    assign w_gdir = r_sync[SYNC_STAGES-1];

    // Addressed register: serves as read data and as the old value for atomic ops
    always_comb begin
        w_cur = i_reg == GDOR ? r_gdor :
                i_reg == GOER ? r_goer :
                i_reg == GAFR ? r_gafr :
                i_reg == GPER ? r_gper :
                i_reg == GIER ? r_gier :
                i_reg == GISR ? r_gisr :
                i_reg == GIFR ? r_gifr :
                i_reg == GDIR ? w_gdir :
                i_reg == GCMR ? r_gcmr : '0;
    end

    assign w_next    = WIDTH'(next_val(i_op, 32'(i_wdata), 32'(w_cur)));
    assign w_edge    = (r_gcmr & w_gdir & ~r_prev) | (~r_gcmr & ~w_gdir & r_prev);
    assign w_event   = (r_gisr & w_edge) | (~r_gisr & ~(w_gdir ^ r_gcmr));
    assign o_rdata   = w_cur;
    assign o_irq_req = |(r_gifr & r_gier);
    assign o_gdor    = r_gdor;
    assign o_goer    = r_goer;
    assign o_gafr    = r_gafr;
    assign o_gper    = r_gper;

    // Register update; new events are ORed in after a W1C so a same-cycle event wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gdor <= '0;
            r_goer <= '0;
            r_gafr <= '0;
            r_gper <= '0;
            r_gier <= '0;
            r_gisr <= '0;
            r_gcmr <= '0;
            r_gifr <= '0;
        end else begin
            if (i_we && i_reg == GDOR) r_gdor <= w_next;
            if (i_we && i_reg == GOER) r_goer <= w_next;
            if (i_we && i_reg == GAFR) r_gafr <= w_next;
            if (i_we && i_reg == GPER) r_gper <= w_next;
            if (i_we && i_reg == GIER) r_gier <= w_next;
            if (i_we && i_reg == GISR) r_gisr <= w_next;
            if (i_we && i_reg == GCMR) r_gcmr <= w_next;
            r_gifr <= (i_we && i_reg == GIFR ? w_next : r_gifr) | w_event;
        end
    end

    // Pad synchroniser chain plus one-cycle history of its output for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_pins;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_gdir;
        end
    end
endmodule

// File: rtl/ehl_gpio_bank.sv
// ehl_gpio_bank: multi-port GPIO register bank with atomic ops, sticky interrupt flags and one irq
module ehl_gpio_bank
    import ehl_gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NPORTS      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ATOMIC_ENA  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    ehl_gpio_bank_if.slave          bus,
    input  logic [NPORTS*WIDTH-1:0] gpio_in,
    output logic [NPORTS*WIDTH-1:0] gpio_out,
    output logic [NPORTS*WIDTH-1:0] gpio_oe,
    output logic [NPORTS*WIDTH-1:0] gpio_af,
    output logic [NPORTS*WIDTH-1:0] gpio_pe,
    output logic                    irq
);
    logic [31:0]       w_port;
    logic [3:0]        w_reg;
    logic [1:0]        w_op;
    logic              w_port_ok, w_wr_ok, w_rd_ok, w_we;
    logic [WIDTH-1:0]  w_prd [NPORTS];
    logic [WIDTH-1:0]  w_rdata;
    logic [NPORTS-1:0] w_irq_req;
    logic [WIDTH-1:0]  r_data_out;
    logic              r_rd_valid, r_err, r_irq;

    assign w_port    = 32'(bus.addr) >> 6;
    assign w_reg     = bus.addr[5:2];
    assign w_op      = bus.addr[1:0];
    assign w_port_ok = w_port < 32'(NPORTS);
    // GIFR only accepts write-1-to-clear; it is its sole clear path, so it stays legal without atomics
    assign w_wr_ok   = w_port_ok && (w_reg == GIFR ? w_op == OP_CLR :
                       is_rw_reg(w_reg) && (ATOMIC_ENA != 0 || w_op == OP_WR));
    assign w_rd_ok   = w_port_ok && w_op == OP_WR && is_rd_reg(w_reg);
    assign w_we      = bus.wr && w_wr_ok;

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        ehl_gpio_port #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_port (
            .clk      (clk),
            .reset    (reset),
            .i_we     (w_we && w_port == 32'(g)),
            .i_reg    (w_reg),
            .i_op     (w_op),
            .i_wdata  (bus.data_in),
            .o_rdata  (w_prd[g]),
            .i_pins   (gpio_in[g*WIDTH +: WIDTH]),
            .o_gdor   (gpio_out[g*WIDTH +: WIDTH]),
            .o_goer   (gpio_oe[g*WIDTH +: WIDTH]),
            .o_gafr   (gpio_af[g*WIDTH +: WIDTH]),
            .o_gper   (gpio_pe[g*WIDTH +: WIDTH]),
            .o_irq_req(w_irq_req[g])
        );
    end

    // Read mux across ports
    always_comb begin
        w_rdata = '0;
        for (int p = 0; p < NPORTS; p++) w_rdata |= w_port == 32'(p) ? w_prd[p] : '0;
    end

    // Registered bus response and combined interrupt; a simultaneous rd is dropped in favour of wr
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd && !bus.wr;
            r_err      <= bus.wr ? (!w_wr_ok || bus.rd) : (bus.rd && !w_rd_ok);
            if (bus.rd && !bus.wr) r_data_out <= w_rd_ok ? w_rdata : '0;
            r_irq      <= |w_irq_req;
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.rd_valid = r_rd_valid;
    assign bus.err      = r_err;
    assign irq          = r_irq;
endmodule
